// File: rtl/hls_deadlock_pkg.sv
// Shared types and width helpers for the deadlock reporter and its priority encoder.
package hls_deadlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMING = 2'd1,
        ST_REPORT = 2'd2,
        ST_DONE   = 2'd3
    } fsm_state_e;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Index width never drops below one bit so a single monitor still has an id port.
    function automatic int id_width(input int num_mon);
        return (num_mon > 1) ? clog2(num_mon) : 1;
    endfunction

    function automatic int dwell_width(input int thresh);
        return (thresh > 0) ? clog2(thresh + 1) : 1;
    endfunction

endpackage

// File: rtl/hls_deadlock_prienc.sv
// Lowest-set-bit encoder: reports the index of the lowest blocked monitor, 0 when none.
module hls_deadlock_prienc
    import hls_deadlock_pkg::*;
#(
    parameter int NUM_MON = 4,
    parameter int ID_W    = id_width(NUM_MON)
) (
    input  logic [NUM_MON-1:0] vec_i,
    output logic [ID_W-1:0]    id_o
);

    // Scan from the top down so the last hit wins, leaving the lowest index.
    always_comb begin
        id_o = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                id_o = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/hls_deadlock_reporter.sv
// Qualifies a sustained monitor block as a deadlock and emits one snapshot report per arm.
module hls_deadlock_reporter
    import hls_deadlock_pkg::*;
#(
    parameter int  NUM_MON = 4,
    parameter int  THRESH  = 1024,
    parameter int  CNT_W   = 32,
    localparam int ID_W    = id_width(NUM_MON),
    localparam int DWELL_W = dwell_width(THRESH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] mon_block,
    input  logic               clear,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [ID_W-1:0]    rpt_id,
    output logic [NUM_MON-1:0] rpt_mask,
    output logic [CNT_W-1:0]   rpt_cycle,
    output logic               deadlock,
    output fsm_state_e         dbg_state
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(THRESH - 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX  = DWELL_W'(THRESH);

    fsm_state_e         state_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [CNT_W-1:0]   cycle_cnt_q;
    logic               rpt_valid_q;
    logic               deadlock_q;
    logic [ID_W-1:0]    rpt_id_q;
    logic [NUM_MON-1:0] rpt_mask_q;
    logic [CNT_W-1:0]   rpt_cycle_q;

    logic               any_block;
    logic               capture;
    logic [ID_W-1:0]    low_id;

    hls_deadlock_prienc #(
        .NUM_MON (NUM_MON),
        .ID_W    (ID_W)
    ) u_prienc (
        .vec_i (mon_block),
        .id_o  (low_id)
    );

    assign any_block = |mon_block;

    // Capture fires on the THRESH-th consecutive blocked cycle; clear suppresses it.
    always_comb begin
        capture = 1'b0;
        case (state_q)
            ST_IDLE:   capture = !clear && any_block && (THRESH == 1);
            ST_ARMING: capture = !clear && any_block && (dwell_q == DWELL_LAST);
            default:   capture = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
        end
    end

    // Report stream: payload is stable while rpt_valid is high and a transfer
    // happens on any edge with rpt_valid && rpt_ready; rpt_ready alone does nothing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            dwell_q     <= '0;
            rpt_valid_q <= 1'b0;
            deadlock_q  <= 1'b0;
            rpt_id_q    <= '0;
            rpt_mask_q  <= '0;
            rpt_cycle_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ARMING: begin
                    if (clear || !any_block) begin
                        dwell_q <= '0;
                        state_q <= ST_IDLE;
                    end else if (capture) begin
                        dwell_q     <= '0;
                        state_q     <= ST_REPORT;
                        rpt_valid_q <= 1'b1;
                        deadlock_q  <= 1'b1;
                        rpt_id_q    <= low_id;
                        rpt_mask_q  <= mon_block;
                        rpt_cycle_q <= cycle_cnt_q;
                    end else if (state_q == ST_IDLE) begin
                        dwell_q <= DWELL_W'(1);
                        state_q <= ST_ARMING;
                    end else if (dwell_q != DWELL_MAX) begin
                        dwell_q <= dwell_q + DWELL_W'(1);
                    end
                end
                ST_REPORT: begin
                    if (rpt_ready) begin
                        rpt_valid_q <= 1'b0;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (clear) begin
                        deadlock_q <= 1'b0;
                        dwell_q    <= '0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rpt_valid = rpt_valid_q;
    assign deadlock  = deadlock_q;
    assign rpt_id    = rpt_id_q;
    assign rpt_mask  = rpt_mask_q;
    assign rpt_cycle = rpt_cycle_q;
    assign dbg_state = state_q;

endmodule

// File: doc/hls_deadlock_reporter.md
Name: hls_deadlock_reporter

Overview:
Consumer end of the per-instance deadlock monitors.
- Collects the `block` outputs of NUM_MON monitors.
- Qualifies a deadlock only when some monitor has been blocking for THRESH consecutive cycles.
- Latches a snapshot of which instance(s) blocked and the cycle of detection.
- Delivers the snapshot once over a valid/ready report stream to the debug/status path.
- Sits at the design-wrapper level, beside the monitor tree.

Parameters:
NUM_MON, 4, number of monitor block inputs (>=1)
THRESH, 1024, consecutive cycles of any-block required to declare deadlock (>=1)
CNT_W, 32, width of free-running cycle timestamp

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
mon_block  in  NUM_MON  block flags from monitors, bit i = monitor i
clear  in  1  single-cycle rearm request
rpt_valid  out  1  report available
rpt_ready  in  1  report consumer ready
rpt_id  out  ID_W  lowest-index blocked monitor at detection; ID_W = max(1, clog2(NUM_MON))
rpt_mask  out  NUM_MON  snapshot of mon_block at detection
rpt_cycle  out  CNT_W  cycle_cnt value at detection
deadlock  out  1  sticky deadlock flag

Behaviour:
- Reset (reset=0, async): FSM=IDLE; dwell=0; cycle_cnt=0. Outputs rpt_valid, rpt_id, rpt_mask, rpt_cycle and deadlock are all 0. Reset mid-operation drops any pending report.
- cycle_cnt: +1 every cycle, wraps from 2^CNT_W-1 to 0. It is never stopped or cleared except by reset.
- any_block = OR of mon_block.
- dwell: width clog2(THRESH+1), saturating.
- IDLE:
  - any_block=1: if THRESH=1, capture and go to REPORT. Otherwise dwell<=1 and go to ARMING.
- ARMING:
  - any_block=0: dwell<=0, go to IDLE.
  - any_block=1 and dwell==THRESH-1: capture and go to REPORT.
  - any_block=1 otherwise: dwell+1.
  - A change in which bits are set does not restart dwell; only an all-zero cycle does.
- Latency: with mon_block nonzero at edges k..k+THRESH-1, capture happens at edge k+THRESH-1. rpt_valid and deadlock are high from that edge.
- Capture (single edge), all registered together:
  - rpt_mask<=mon_block
  - rpt_id<=index of lowest set bit
  - rpt_cycle<=cycle_cnt
  - rpt_valid<=1
  - deadlock<=1
- REPORT:
  - rpt_valid stays high; payload is held stable until rpt_valid&&rpt_ready.
  - mon_block is ignored.
  - On handshake: rpt_valid<=0, go to DONE.
  - clear is ignored in REPORT, including when it coincides with the handshake. A pending report is never dropped.
- DONE:
  - deadlock stays 1; payload registers keep their last values.
  - mon_block is ignored.
  - clear=1: deadlock<=0, dwell<=0, go to IDLE. Monitoring restarts the next cycle.
- clear in IDLE/ARMING: dwell<=0, go to IDLE. clear has priority over any_block in the same cycle, and no capture happens that cycle.
- rpt_ready while rpt_valid=0 has no effect.
- The FSM has exactly one capture per arm; no second report until clear.

Decomposition:
- Package hls_deadlock_pkg:
  - FSM state enum (IDLE, ARMING, REPORT, DONE)
  - clog2 helper function
  - ID_W derivation
- Sub-module hls_deadlock_prienc: combinational lowest-set-bit encoder, NUM_MON -> ID_W, output 0 for all-zero input.
- Counters and FSM stay in the top module.

Test Plan (NUM_MON=4, THRESH=8, CNT_W=32, rpt_ready=1 unless stated):
- Reset release, then mon_block=4'b0100 held from cycle 10 -> capture at edge 17. Required: rpt_valid=1, rpt_id=2, rpt_mask=4'b0100, rpt_cycle=17, deadlock=1. Handshake next edge, then DONE.
- mon_block=4'b0010 for 7 cycles, then 0 for 1 cycle, then 4'b0010 again -> no report until 8 further consecutive cycles. Required: rpt_valid stays 0 throughout the 7-cycle burst.
- mon_block switches 4'b1000 -> 4'b1010 on cycle 5 of arming, stays nonzero -> report still at 8th cycle. Required: rpt_mask=4'b1010, rpt_id=1.
- rpt_ready=0 for 20 cycles after capture while mon_block toggles -> rpt_valid held, payload unchanged. Then rpt_ready=1 -> exactly one handshake, rpt_valid=0.
- clear pulsed in REPORT simultaneously with handshake -> DONE, deadlock=1. Second clear -> IDLE, deadlock=0, and a new 8-cycle block produces a second report.
- Assert reset=0 mid-ARMING (dwell=5) and mid-REPORT -> all outputs 0 immediately (async). After release, 8 fresh cycles are required before capture.
